// File: rtl/source_e_arbiter.sv
// Round-robin arbiter sharing one TileLink E-channel (GrantAck) source
// between N_REQ requesters, feeding a small registered output FIFO.
module source_e_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SINK_W = 3,
    parameter int QDEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           io_req_valid,
    output logic [N_REQ-1:0]           io_req_ready,
    input  logic [N_REQ*SINK_W-1:0]    io_req_bits_sink,
    input  logic                       io_e_ready,
    output logic                       io_e_valid,
    output logic [SINK_W-1:0]          io_e_bits_sink,
    output logic [$clog2(N_REQ)-1:0]   io_last_grant,
    output logic                       io_busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int QW    = $clog2(QDEPTH);
    localparam int CW    = QW + 1;
    localparam logic [CW-1:0]    FULL = CW'(QDEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

    logic [SINK_W-1:0] r_mem [QDEPTH];
    logic [QW-1:0]     r_rd;
    logic [QW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_last;

    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic              w_can;
    logic              w_enq;
    logic              w_deq;
    logic [N_REQ-1:0]  w_ready;
    logic [SINK_W-1:0] w_sink;

    // First valid requester at or after the RR pointer, wrapping.
    always_comb begin : arb
        logic [PTR_W-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && io_req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    assign io_e_valid = (r_count != '0) && !reset;
    assign w_deq      = io_e_valid && io_e_ready;
    // Full FIFO still accepts when the head leaves in the same cycle.
    assign w_can      = (r_count < FULL) || w_deq;
    assign w_enq      = w_found && w_can && !reset;
    assign w_sink     = io_req_bits_sink[int'(w_win)*SINK_W +: SINK_W];

    always_comb begin
        w_ready = '0;
        if (w_enq) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign io_req_ready   = w_ready;
    assign io_e_bits_sink = r_mem[r_rd];
    assign io_last_grant  = reset ? '0 : r_last;
    assign io_busy        = (r_count != '0) || (|io_req_valid);

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[r_wr] <= w_sink;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_ptr   <= '0;
            r_last  <= '0;
        end else begin
            if (w_enq) begin
                r_wr   <= r_wr + QW'(1);
                r_ptr  <= (w_win == LAST) ? '0 : w_win + PTR_W'(1);
                r_last <= w_win;
            end
            if (w_deq) begin
                r_rd <= r_rd + QW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_source_e_arbiter.sv
// Randomized and directed bench for source_e_arbiter against a
// queue-based reference model of the arbiter and output FIFO.
module tb_source_e_arbiter;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int D  = 2;
    localparam int PW = $clog2(N);

    logic              clock;
    logic              reset;
    logic [N-1:0]      io_req_valid;
    logic [N-1:0]      io_req_ready;
    logic [N*W-1:0]    io_req_bits_sink;
    logic              io_e_ready;
    logic              io_e_valid;
    logic [W-1:0]      io_e_bits_sink;
    logic [PW-1:0]     io_last_grant;
    logic              io_busy;

    source_e_arbiter #(.N_REQ(N), .SINK_W(W), .QDEPTH(D)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_req_valid     (io_req_valid),
        .io_req_ready     (io_req_ready),
        .io_req_bits_sink (io_req_bits_sink),
        .io_e_ready       (io_e_ready),
        .io_e_valid       (io_e_valid),
        .io_e_bits_sink   (io_e_bits_sink),
        .io_last_grant    (io_last_grant),
        .io_busy          (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_q[$];
    int m_ptr  = 0;
    int m_last = 0;

    // Requester-side pending requests
    logic   pend [N];
    int     psink[N];
    int     waitc[N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] s,
                        input logic er, input logic rst, output int win);
        int   idx;
        logic deq;
        logic can;
        logic [N-1:0] exp_rdy;
        win = -1;
        @(negedge clock);
        io_req_valid     = v;
        io_req_bits_sink = s;
        io_e_ready       = er;
        reset            = rst;
        #1;
        chk("busy", io_busy, (m_q.size() != 0) || (|v));
        if (rst) begin
            chk("rst_ready", io_req_ready, 0);
            chk("rst_evalid", io_e_valid, 0);
            chk("rst_last", io_last_grant, 0);
            m_q.delete();
            m_ptr  = 0;
            m_last = 0;
        end else begin
            chk("e_valid", io_e_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("e_sink", io_e_bits_sink, m_q[0]);
            chk("last_grant", io_last_grant, m_last);
            deq = (m_q.size() != 0) && er;
            can = (m_q.size() < D) || deq;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (win < 0 && v[idx]) win = idx;
            end
            if (!can) win = -1;
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", io_req_ready, exp_rdy);
            if (deq) void'(m_q.pop_front());
            if (win >= 0) begin
                m_q.push_back(int'(s[win*W +: W]));
                m_ptr  = (win + 1) % N;
                m_last = win;
            end
        end
    endtask

    task automatic run(input logic er, input logic rst);
        logic [N-1:0]   v;
        logic [N*W-1:0] s;
        int win;
        v = '0;
        s = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = pend[i];
            s[i*W +: W] = W'(psink[i]);
        end
        step(v, s, er, rst, win);
        if (rst) begin
            for (int i = 0; i < N; i++) waitc[i] = 0;
        end else if (win >= 0) begin
            chk("fair", waitc[win] < N, 1);
            waitc[win] = 0;
            pend[win]  = 1'b0;
            for (int i = 0; i < N; i++)
                if (pend[i]) waitc[i]++;
        end
    endtask

    task automatic req(input int i, input int sink);
        pend[i]  = 1'b1;
        psink[i] = sink;
        waitc[i] = 0;
    endtask

    initial begin
        io_req_valid     = '0;
        io_req_bits_sink = '0;
        io_e_ready       = 1'b0;
        reset            = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            psink[i] = 0;
            waitc[i] = 0;
        end
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);

        // All four valid, drained every cycle
        req(0, 5); req(1, 6); req(2, 7); req(3, 1);
        repeat (6) run(1'b1, 1'b0);

        // Stall: 2 then 3 fill the FIFO, then one dequeue admits 0
        req(2, 3); req(3, 4);
        repeat (4) run(1'b0, 1'b0);
        req(0, 6);
        run(1'b1, 1'b0);
        repeat (2) run(1'b0, 1'b0);

        // Full FIFO streaming with requester 1 always valid
        repeat (6) begin
            if (!pend[1]) req(1, 2);
            run(1'b1, 1'b0);
        end
        repeat (3) run(1'b1, 1'b0);

        // Pointer after grant to 1 is 2: 3 wins, then 0 over 3
        req(1, 1);
        run(1'b1, 1'b0);
        req(3, 5);
        run(1'b1, 1'b0);
        req(0, 2); req(3, 6);
        run(1'b1, 1'b0);
        repeat (3) run(1'b1, 1'b0);

        // Reset with two buffered entries
        req(1, 3); req(2, 4);
        repeat (3) run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        req(0, 1); req(2, 5);
        repeat (4) run(1'b1, 1'b0);

        // Idle, then a single request from 1
        repeat (2) run(1'b1, 1'b0);
        req(1, 7);
        repeat (3) run(1'b1, 1'b0);

        // Random traffic
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    req(i, $urandom_range(0, (1 << W) - 1));
            run($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
